// File: rtl/phy_stim_gen_chk.sv
// Lane stimulus generator (incrementing data, valid/idle framing) with a
// registered comparator scoring two DUT output streams against each other.
//
// state  | meaning
// S_IDLE | waiting for start; outputs parked
// S_RUN  | valid beats, data incrementing per lane
// S_GAP  | valid low, data still incrementing
// S_END  | one-cycle done pulse, data and idle cleared
module phy_stim_gen_chk #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 8,
    parameter logic [N_CH*DATA_W-1:0] INC_VEC = {8'd4, 8'd3, 8'd2, 8'd4},
    parameter int SEED_STEP = 1,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     start,
    input  logic [DATA_W-1:0]        seed_base,
    input  logic [LEN_W-1:0]         len,
    input  logic [LEN_W-1:0]         gap,
    input  logic                     chk_en,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          valid_out,
    output logic                     idle_out,
    output logic                     busy,
    output logic                     done,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     a_valid,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     b_valid,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic [CNT_W-1:0]         first_err_cycle,
    output logic                     err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_END} state_t;

    state_t                   state, state_nxt;
    logic [N_CH*DATA_W-1:0]   data_r, data_nxt, data_inc, seed_vec;
    logic                     valid_r, valid_nxt;
    logic                     idle_r, idle_nxt;
    logic [LEN_W-1:0]         beat, beat_nxt;
    logic [LEN_W-1:0]         len_r, len_nxt;
    logic [LEN_W-1:0]         gap_r, gap_nxt;
    logic                     start_acc;
    logic [CNT_W-1:0]         cyc;
    logic                     mism;

    always_comb begin
        data_inc = '0;
        seed_vec = '0;
        for (int k = 0; k < N_CH; k++) begin
            data_inc[k*DATA_W +: DATA_W] = data_r[k*DATA_W +: DATA_W] + INC_VEC[k*DATA_W +: DATA_W];
            seed_vec[k*DATA_W +: DATA_W] = seed_base + DATA_W'(k * SEED_STEP);
        end
    end

    // Every entry into S_END clears data, valid and idle so the end cycle looks the same
    // regardless of which state it came from.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_r;
        valid_nxt = valid_r;
        idle_nxt  = idle_r;
        beat_nxt  = beat;
        len_nxt   = len_r;
        gap_nxt   = gap_r;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    data_nxt  = seed_vec;
                    beat_nxt  = LEN_W'(1);
                    len_nxt   = len;
                    gap_nxt   = gap;
                    idle_nxt  = 1'b1;
                    if (len != '0) begin
                        valid_nxt = 1'b1;
                        state_nxt = S_RUN;
                    end else if (gap != '0) begin
                        valid_nxt = 1'b0;
                        state_nxt = S_GAP;
                    end else begin
                        valid_nxt = 1'b0;
                        data_nxt  = '0;
                        idle_nxt  = 1'b0;
                        state_nxt = S_END;
                    end
                end
            end
            S_RUN: begin
                data_nxt = data_inc;
                if (beat == len_r) begin
                    valid_nxt = 1'b0;
                    beat_nxt  = LEN_W'(1);
                    if (gap_r != '0) begin
                        state_nxt = S_GAP;
                    end else begin
                        data_nxt  = '0;
                        idle_nxt  = 1'b0;
                        state_nxt = S_END;
                    end
                end else begin
                    beat_nxt = beat + LEN_W'(1);
                end
            end
            S_GAP: begin
                data_nxt  = data_inc;
                valid_nxt = 1'b0;
                if (beat == gap_r) begin
                    data_nxt  = '0;
                    idle_nxt  = 1'b0;
                    state_nxt = S_END;
                end else begin
                    beat_nxt = beat + LEN_W'(1);
                end
            end
            S_END: begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
                idle_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state   <= S_IDLE;
            data_r  <= '0;
            valid_r <= 1'b0;
            idle_r  <= 1'b1;
            beat    <= '0;
            len_r   <= '0;
            gap_r   <= '0;
        end else begin
            state   <= state_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            idle_r  <= idle_nxt;
            beat    <= beat_nxt;
            len_r   <= len_nxt;
            gap_r   <= gap_nxt;
        end
    end

    assign mism = chk_en && ((a_valid != b_valid) || (a_valid && (a_data != b_data)));

    // A start accepted on the same edge as a mismatch clears the score; the mismatch is dropped.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cyc             <= '0;
            mismatch_cnt    <= '0;
            first_err_cycle <= '0;
            err             <= 1'b0;
        end else if (start_acc) begin
            cyc             <= '0;
            mismatch_cnt    <= '0;
            first_err_cycle <= '0;
            err             <= 1'b0;
        end else begin
            if (cyc != '1)
                cyc <= cyc + CNT_W'(1);
            if (mism) begin
                if (mismatch_cnt != '1)
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                err <= 1'b1;
                if (!err)
                    first_err_cycle <= cyc;
            end
        end
    end

    assign data_out  = data_r;
    assign valid_out = {N_CH{valid_r}};
    assign idle_out  = idle_r;
    assign busy      = (state == S_RUN) || (state == S_GAP);
    assign done      = (state == S_END);

endmodule

// File: tb/tb_phy_stim_gen_chk.sv
// Scoreboard bench for phy_stim_gen_chk: expected beats are queued at start,
// popped by a monitor whenever valid_out is high; framing and scoring checked per cycle.
module tb_phy_stim_gen_chk;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed_base = '0;
    logic [7:0]  len = '0;
    logic [7:0]  gap = '0;
    logic        chk_en = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        idle_out, busy, done;
    logic [7:0]  a_data = '0, b_data = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] mismatch_cnt, first_err_cycle;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];
    int inc_tab[4] = '{4, 2, 3, 4};

    phy_stim_gen_chk dut (
        .clk(clk), .reset_L(reset_L), .start(start), .seed_base(seed_base),
        .len(len), .gap(gap), .chk_en(chk_en), .data_out(data_out),
        .valid_out(valid_out), .idle_out(idle_out), .busy(busy), .done(done),
        .a_data(a_data), .a_valid(a_valid), .b_data(b_data), .b_valid(b_valid),
        .mismatch_cnt(mismatch_cnt), .first_err_cycle(first_err_cycle), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_exp(input logic [7:0] seed, input int j);
        logic [31:0] v;
        for (int k = 0; k < 4; k++)
            v[k*8 +: 8] = 8'(int'(seed) + k + j * inc_tab[k]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset_L && valid_out[0]) begin
            if (sb_q.size() == 0)
                chk("sb_empty", 64'(data_out), 64'hDEAD);
            else
                chk("beat", 64'(data_out), 64'(sb_q.pop_front()));
        end
    end

    // mode: 0 plain, 1 start re-pulsed mid-run, 2 comparator stimulus, 3 reset during gap
    task automatic run(input logic [7:0] s, input int l, input int g, input int mode);
        int n;
        n = l + g;
        for (int j = 0; j < l; j++)
            sb_q.push_back(beat_exp(s, j));
        @(negedge clk);
        seed_base = s;
        len = 8'(l);
        gap = 8'(g);
        start = 1'b1;
        if (mode == 2) chk_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i <= n + 3; i++) begin
            @(negedge clk);
            chk("valid", 64'(valid_out), (i < l) ? 64'hF : 64'h0);
            chk("done", 64'(done), 64'(i == n));
            chk("busy", 64'(busy), 64'(i < n));
            chk("idle", 64'(idle_out), 64'(i < n));
            if (i == n) chk("end_data", 64'(data_out), 64'h0);
            if (i == 0) begin
                chk("err_clr", 64'(err), 64'h0);
                chk("cnt_clr", 64'(mismatch_cnt), 64'h0);
            end
            if (mode == 1) begin
                start = (i == 2);
                seed_base = 8'hC3;
                len = 8'd1;
            end
            if (mode == 2) begin
                if (i == 10) begin
                    chk("err_clean", 64'(err), 64'h0);
                    chk("cnt_clean", 64'(mismatch_cnt), 64'h0);
                end
                if (i == 14) begin
                    chk("err_set", 64'(err), 64'h1);
                    chk("cnt_1", 64'(mismatch_cnt), 64'h1);
                    chk("first_12", 64'(first_err_cycle), 64'd12);
                end
                if (i == 16) begin
                    chk("cnt_2", 64'(mismatch_cnt), 64'h2);
                    chk("first_keep", 64'(first_err_cycle), 64'd12);
                    chk("err_keep", 64'(err), 64'h1);
                end
                a_valid = 1'b1;
                b_valid = (i != 14);
                a_data  = 8'(i);
                b_data  = (i == 12) ? 8'(i ^ 1) : 8'(i);
            end
            if (mode == 3 && i == 6) begin
                reset_L = 1'b0;
                #1;
                chk("rst_data", 64'(data_out), 64'h0);
                chk("rst_valid", 64'(valid_out), 64'h0);
                chk("rst_idle", 64'(idle_out), 64'h1);
                chk("rst_busy", 64'(busy), 64'h0);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("rst_nodone", 64'(done), 64'h0);
                    if (c == 1) reset_L = 1'b1;
                end
                chk("rst_idle_after", 64'(idle_out), 64'h1);
                sb_q.delete();
                break;
            end
        end
        chk_en = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data = '0;
        b_data = '0;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_L = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idle", 64'(idle_out), 64'h1);
        chk("rst_valid", 64'(valid_out), 64'h0);
        chk("rst_data", 64'(data_out), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_cnt", 64'(mismatch_cnt), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        reset_L = 1'b1;
        @(negedge clk);
        chk("beat0_explicit", 64'(beat_exp(8'h0A, 1)), 64'h110F0D0E);
        run(8'h0A, 5, 3, 0);
        run(8'hFE, 2, 0, 0);
        run(8'h00, 0, 0, 0);
        run(8'h30, 20, 2, 2);
        run(8'h55, 6, 2, 1);
        run(8'h11, 4, 6, 3);
        run(8'h80, 0, 3, 0);
        repeat (2) @(negedge clk);
        chk("sb_left", 64'(sb_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phy_stim_gen_chk.md
Name: phy_stim_gen_chk

Overview:
- Synthesisable, parametrised lane stimulus generator with a built-in dual-output comparator for the phy_tx datapath.
- Generates N_CH lanes of incrementing data with valid and idle control, sized by run-time beat and gap counts.
- Compares the behavioural (cond) and synthesised (synt) DUT outputs every cycle.
- Replaces hand-written per-bench stimulus so the same block can drive and score any lane count or width.

Parameters:
N_CH, 4, number of generated lanes
DATA_W, 8, lane data width
INC_VEC, {8'd4,8'd3,8'd2,8'd4}, packed N_CH*DATA_W per-lane increment; lane k uses slice [k*DATA_W +: DATA_W] (k=0 is LSB slice)
SEED_STEP, 1, seed offset between adjacent lanes
LEN_W, 8, width of beat/gap counters
CNT_W, 16, width of cycle and mismatch counters

Ports:
clk  input  1  single clock, all state on posedge
reset_L  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in S_IDLE
seed_base  input  DATA_W  lane 0 first data word
len  input  LEN_W  number of valid beats
gap  input  LEN_W  number of valid-low beats after the valid beats
chk_en  input  1  comparator enable
data_out  output  N_CH*DATA_W  lane data, lane k at [k*DATA_W +: DATA_W]
valid_out  output  N_CH  per-lane valid (all lanes identical)
idle_out  output  1  idle indication to the DUT
busy  output  1  high in S_RUN and S_GAP
done  output  1  one-cycle pulse at end of run
a_data  input  DATA_W  cond DUT data
a_valid  input  1  cond DUT valid
b_data  input  DATA_W  synt DUT data
b_valid  input  1  synt DUT valid
mismatch_cnt  output  CNT_W  saturating mismatch count
first_err_cycle  output  CNT_W  cycle index of first mismatch
err  output  1  sticky mismatch flag

Behaviour:
- Reset (reset_L=0, asynchronous): state S_IDLE; data_out=0; valid_out=0; idle_out=1; busy=0; done=0; mismatch_cnt=0; first_err_cycle=0; err=0; internal cycle counter=0.
- FSM states: S_IDLE, S_RUN, S_GAP, S_END.
- S_IDLE, start=1:
  - Lane k data <= seed_base + k*SEED_STEP, mod 2^DATA_W.
  - Beat counter <= 1; cycle counter, mismatch_cnt, first_err_cycle and err cleared.
  - idle_out <= 1.
  - If len!=0: valid_out <= all ones, go to S_RUN.
  - If len==0 and gap!=0: valid_out <= 0, go to S_GAP.
  - If len==0 and gap==0: go to S_END.
- S_RUN:
  - Each cycle, lane k data <= data + INC_k (wraps, no carry out).
  - When beat counter == len: valid_out <= 0 on that same edge; go to S_GAP if gap!=0, else S_END. Reset beat counter to 1 on the transition.
  - Otherwise beat counter++.
  - Result: valid_out is high for exactly len cycles.
- S_GAP:
  - Data keeps incrementing; valid_out=0.
  - After gap cycles (beat counter == gap), go to S_END.
  - On the S_GAP to S_END edge, idle_out <= 0.
- S_END (one cycle):
  - data_out <= 0; valid_out <= 0; done=1; idle_out=0; then S_IDLE.
  - idle_out stays 0 in S_IDLE until the next accepted start sets it to 1.
- start is ignored in S_RUN, S_GAP and S_END; no queuing.
- len and gap are sampled only at start. Changes mid-run have no effect.
- Cycle counter: increments every cycle from the start edge; saturates at all-ones.
- Comparator (registered, 1-cycle latency), active when chk_en=1 in any state:
  - Mismatch when a_valid != b_valid, or a_valid=b_valid=1 and a_data != b_data.
  - Data is ignored when both valids are 0.
  - On mismatch: mismatch_cnt++ (saturates at 2^CNT_W-1); err <= 1.
  - If err was 0, first_err_cycle <= current cycle counter.
- A start accepted on the same edge as a mismatch: the clear wins; the mismatch is discarded.
- Reset mid-run aborts immediately to reset values; no done pulse.

Test Plan:
1. Reset defaults: hold reset_L=0 for 3 cycles -> idle_out=1, valid_out=0, data_out=0, err=0.
2. Defaults, seed_base=8'h0A, len=5, gap=3:
   - First valid beat has lanes 0..3 = 0A,0B,0C,0D; second beat = 0E,0D,0F,11.
   - valid_out high exactly 5 cycles, then low 3 cycles; idle_out falls entering S_END.
   - done pulses once, 9 cycles after start; data_out=0 in S_END.
3. Wrap: seed_base=8'hFE, len=2 -> lane 0 data FE then 02; lane 1 FF then 01.
4. len=0, gap=0 -> valid_out never asserts; done pulses on the cycle after start.
5. Comparator, chk_en=1:
   - Identical a/b streams for 10 cycles -> err=0, mismatch_cnt=0.
   - Then b_data differs on cycle index 12 only -> err=1, mismatch_cnt=1, first_err_cycle=12.
   - a_valid=1, b_valid=0 on cycle 14 -> mismatch_cnt=2; first_err_cycle stays 12.
6. start pulsed again during S_RUN -> ignored, sequence unchanged. reset_L low during S_GAP -> all outputs to reset values, no done.
